mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between `exe_stage` and the writeback stage. It registers the EXE-to-MEM bus under valid/allow-in handshaking and selects the writeback value (ALU result, load data, PC+4, or old CSR value). It computes the CSR write data for Zicsr read-modify-write ops and drives the MEM-to-ID bypass bus. When synchronous data RAM is configured, it captures load data that arrives one cycle after the address and holds it across writeback stalls.

## Interface
- `XLEN`, `` `XLEN `` from cpu.vh: datapath width.
- `PC_WIDTH`, `` `PC_WIDTH ``: PC width.
- `EXE_TO_MEM_BUS_WIDTH`, `` `EXE_TO_MEM_BUS_WIDTH ``: input bus width.
- `MEM_TO_WB_BUS_WIDTH`, `` `MEM_TO_WB_BUS_WIDTH `` = PC_WIDTH+XLEN+1+5+1+12+XLEN+2: output bus width.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `exe_to_mem_valid` in 1: EXE holds a valid instruction ready to advance.
- `mem_allow_in` out 1: MEM can accept this cycle.
- `wb_allow_in` in 1: WB can accept this cycle.
- `mem_to_wb_valid` out 1: MEM output is valid.
- `mem_valid` out 1: MEM holds a live instruction.
- `system_flush` in 1: kills the MEM instruction.
- `mem_inst_csr` out 1: a valid CSR instruction is in MEM (hazard detection).
- `exe_to_mem_bus` in EXE_TO_MEM_BUS_WIDTH: {pc, result, rf_wr_sel[1:0], rf_wr_en, reg_waddr[4:0], dram_rdata, csr_idx[XLEN], csr_data_ctrl[3:0], csr_data, system_inst_ctrl[1:0]}, MSB first.
- `data_sram_rdata` in XLEN: synchronous-RAM read data. Used only with DRAM_SYNC_EN.
- `mem_to_wb_bus` out MEM_TO_WB_BUS_WIDTH: {pc, wb_data, rf_wr_en, reg_waddr, csr_wr_en, csr_idx[11:0], csr_wdata, system_inst_ctrl}.
- `mem_to_id_bypass_bus` out `` `BYPASS_BUS_WIDTH ``: {rf_wr_en & mem_valid, reg_waddr, wb_data}.

## Operation
- Handshake:
  - mem_ready_go = 1.
  - mem_allow_in = !mem_valid || wb_allow_in.
  - mem_to_wb_valid = mem_valid.
- mem_valid update, in priority order:
  - reset → 0.
  - system_flush → 0.
  - mem_allow_in → exe_to_mem_valid.
- Pipeline register loads exe_to_mem_bus only on mem_allow_in && exe_to_mem_valid. Otherwise it holds.
- Load data ld_data:
  - Without the macro: the registered dram_rdata field.
  - With the macro: see Configuration.
- wb_data by rf_wr_sel:
  - 00 → result.
  - 01 → ld_data.
  - 10 → pc+4, truncated to XLEN.
  - 11 → csr_data (old CSR value).
- CSR handling:
  - csr_data_ctrl[3] marks a CSR instruction. Its op field is [1:0].
  - csr_wr_en = ctrl[3] & mem_valid & (op != 00).
  - csr_wdata by op:
    - 01 → result.
    - 10 → csr_data | result.
    - 11 → csr_data & ~result.
    - 00 → csr_data.
  - csr_idx output = csr_idx[11:0].
- mem_inst_csr = csr_data_ctrl[3] & mem_valid.
- In the outgoing bus, rf_wr_en is gated with mem_valid.

## Timing
- Latency is one cycle: data accepted at edge N appears on mem_to_wb_bus after edge N.
- Reset values:
  - mem_valid 0, pipeline register 0, hold_valid 0.
  - Therefore mem_allow_in=1, mem_to_wb_valid=0, mem_inst_csr=0.
  - Bypass write-enable bit 0; csr_wr_en 0.
- Back-to-back throughput is one instruction per cycle while wb_allow_in=1.
- If wb_allow_in=0 while mem_valid=1, all outputs hold stable until it rises.
- Simultaneous system_flush and a new accept: flush wins. mem_valid=0 and hold_valid clears.
- Reset asserted mid-operation: all state clears immediately, asynchronously.

## Configuration
- Macro `DRAM_SYNC_EN`.
- Defined:
  - Load data arrives on `data_sram_rdata` in the first MEM cycle of an instruction, and only then.
  - A flag `first_cycle` is set on accept and cleared on the next edge.
  - If first_cycle=1 and the instruction is not leaving (wb_allow_in=0), capture the data into rdata_hold and set hold_valid.
  - ld_data = hold_valid ? rdata_hold : data_sram_rdata.
  - hold_valid clears on leave (mem_valid && wb_allow_in), on flush, or on reset.
- Not defined:
  - The `data_sram_rdata` port is ignored.
  - ld_data = the registered bus dram_rdata field.
  - No hold logic is built.

## Test plan
- Reset with rst=0, then release: mem_allow_in=1, mem_to_wb_valid=0, bypass enable 0. Then accept an ALU op with result=0x1234, waddr=5, sel=00: the next cycle wb_data=0x1234, bypass={1,5,0x1234}.
- JAL with pc=0x80000010, sel=10: wb_data=0x80000014.
- CSRRS with csr_data=0x0F, result=0xF0, op=10: wb_data=0x0F, csr_wdata=0xFF, csr_wr_en=1. CSRRC with csr_data=0xFF, result=0x0F, op=11: csr_wdata=0xF0.
- Stall: hold wb_allow_in=0 for 3 cycles with a valid instruction in MEM. mem_allow_in=0 and the outputs stay frozen. Changes on exe_to_mem_bus are ignored.
- system_flush in the same cycle as exe_to_mem_valid=1: mem_valid=0 next cycle and csr_wr_en=0.
- With DRAM_SYNC_EN: a load is accepted, rdata=0xDEADBEEF in the first MEM cycle, wb_allow_in=0 for 2 cycles, and rdata changes to 0x0 afterward. wb_data stays 0xDEADBEEF until the instruction leaves.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: EXE->MEM pipeline register, writeback select, CSR write data, MEM->ID bypass (optional DRAM_SYNC_EN load-data hold)
module mem_stage #(
   parameter int XLEN                 = 32,
   parameter int PC_WIDTH             = 32,
   parameter int EXE_TO_MEM_BUS_WIDTH = PC_WIDTH + 4*XLEN + 14,
   parameter int MEM_TO_WB_BUS_WIDTH  = PC_WIDTH + XLEN + 1 + 5 + 1 + 12 + XLEN + 2,
   parameter int BYPASS_BUS_WIDTH     = 1 + 5 + XLEN
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            exe_to_mem_valid,
   output logic                            mem_allow_in,
   input  logic                            wb_allow_in,
   output logic                            mem_to_wb_valid,
   output logic                            mem_valid,
   input  logic                            system_flush,
   output logic                            mem_inst_csr,
   input  logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
   input  logic [XLEN-1:0]                 data_sram_rdata,
   output logic [MEM_TO_WB_BUS_WIDTH-1:0]  mem_to_wb_bus,
   output logic [BYPASS_BUS_WIDTH-1:0]     mem_to_id_bypass_bus
);
   logic                            mem_valid_q, mem_valid_d;
   logic [EXE_TO_MEM_BUS_WIDTH-1:0] bus_q, bus_d;
   logic [PC_WIDTH-1:0]             pc, pc_plus4;
   logic [XLEN-1:0]                 result, dram_rdata, csr_idx, csr_data, ld_data, wb_data, csr_wdata;
   logic [1:0]                      rf_wr_sel, sys_ctrl, csr_op;
   logic                            rf_wr_en, csr_wr_en, accept;
   logic [4:0]                      reg_waddr;
   logic [3:0]                      csr_ctrl;

   assign {pc, result, rf_wr_sel, rf_wr_en, reg_waddr, dram_rdata, csr_idx, csr_ctrl, csr_data, sys_ctrl} = bus_q;
   assign mem_allow_in    = !mem_valid_q || wb_allow_in;
   assign mem_to_wb_valid = mem_valid_q;
   assign mem_valid       = mem_valid_q;
   assign accept          = mem_allow_in && exe_to_mem_valid;

   // flush beats accept; the bus register only moves when a new instruction is taken
   always_comb begin
      mem_valid_d = system_flush ? 1'b0 : mem_allow_in ? exe_to_mem_valid : mem_valid_q;
      bus_d       = accept ? exe_to_mem_bus : bus_q;
   end

   // pipeline state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_valid_q <= 1'b0;
         bus_q       <= '0;
      end else begin
         mem_valid_q <= mem_valid_d;
         bus_q       <= bus_d;
      end
   end

`ifdef DRAM_SYNC_EN
   logic            first_cycle_q, first_cycle_d, hold_valid_q, hold_valid_d, capture;
   logic [XLEN-1:0] rdata_hold_q, rdata_hold_d;
   logic            unused;

   assign unused  = ^dram_rdata;
   assign capture = first_cycle_q && !wb_allow_in;
   assign ld_data = hold_valid_q ? rdata_hold_q : data_sram_rdata;

   // RAM data is only present in the first MEM cycle, so latch it if WB stalls us then
   always_comb begin
      first_cycle_d = accept && !system_flush;
      hold_valid_d  = (system_flush || (mem_valid_q && wb_allow_in)) ? 1'b0 : capture ? 1'b1 : hold_valid_q;
      rdata_hold_d  = capture ? data_sram_rdata : rdata_hold_q;
   end

   // load-data hold state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first_cycle_q <= 1'b0;
         hold_valid_q  <= 1'b0;
         rdata_hold_q  <= '0;
      end else begin
         first_cycle_q <= first_cycle_d;
         hold_valid_q  <= hold_valid_d;
         rdata_hold_q  <= rdata_hold_d;
      end
   end
`else
   logic unused;

   assign unused  = ^data_sram_rdata;
   assign ld_data = dram_rdata;
`endif

   logic unused_fields;
   assign unused_fields = ^{csr_idx[XLEN-1:12], csr_ctrl[2]};

   // writeback value and Zicsr read-modify-write data
   always_comb begin
      csr_op    = csr_ctrl[1:0];
      pc_plus4  = pc + PC_WIDTH'(4);
      wb_data   = rf_wr_sel == 2'b00 ? result :
                  rf_wr_sel == 2'b01 ? ld_data :
                  rf_wr_sel == 2'b10 ? XLEN'(pc_plus4) : csr_data;
      csr_wdata = csr_op == 2'b01 ? result :
                  csr_op == 2'b10 ? (csr_data | result) :
                  csr_op == 2'b11 ? (csr_data & ~result) : csr_data;
      csr_wr_en = csr_ctrl[3] & mem_valid_q & (csr_op != 2'b00);
   end

   assign mem_inst_csr         = csr_ctrl[3] & mem_valid_q;
   assign mem_to_wb_bus        = {pc, wb_data, rf_wr_en & mem_valid_q, reg_waddr, csr_wr_en, csr_idx[11:0], csr_wdata, sys_ctrl};
   assign mem_to_id_bypass_bus = {rf_wr_en & mem_valid_q, reg_waddr, wb_data};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
   logic         clk = 0, rst = 0;
   logic         exe_to_mem_valid = 0, wb_allow_in = 1, system_flush = 0;
   logic         mem_allow_in, mem_to_wb_valid, mem_valid, mem_inst_csr;
   logic [173:0] exe_to_mem_bus = '0;
   logic [31:0]  data_sram_rdata = '0;
   logic [116:0] mem_to_wb_bus;
   logic [37:0]  mem_to_id_bypass_bus;
   int           n_checks = 0, n_fails = 0;

   mem_stage dut (
      .clk(clk), .rst(rst), .exe_to_mem_valid(exe_to_mem_valid), .mem_allow_in(mem_allow_in),
      .wb_allow_in(wb_allow_in), .mem_to_wb_valid(mem_to_wb_valid), .mem_valid(mem_valid),
      .system_flush(system_flush), .mem_inst_csr(mem_inst_csr), .exe_to_mem_bus(exe_to_mem_bus),
      .data_sram_rdata(data_sram_rdata), .mem_to_wb_bus(mem_to_wb_bus),
      .mem_to_id_bypass_bus(mem_to_id_bypass_bus)
   );

   always #5 clk = ~clk;

   wire [31:0] wb_data   = mem_to_wb_bus[84:53];
   wire        wb_we     = mem_to_wb_bus[52];
   wire        csr_we    = mem_to_wb_bus[46];
   wire [11:0] csr_idx   = mem_to_wb_bus[45:34];
   wire [31:0] csr_wdata = mem_to_wb_bus[33:2];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [173:0] mk(input logic [31:0] pc, input logic [31:0] res, input logic [1:0] sel,
                                       input logic we, input logic [4:0] wa, input logic [31:0] rd,
                                       input logic [3:0] ctrl, input logic [31:0] cd);
      return {pc, res, sel, we, wa, rd, 32'h0000_0300, ctrl, cd, 2'b00};
   endfunction

   task automatic issue(input logic [173:0] b);
      exe_to_mem_bus   = b;
      exe_to_mem_valid = 1;
      @(posedge clk); #1;
      exe_to_mem_valid = 0;
   endtask

   initial begin
      #12;
      check("rst_allow_in", mem_allow_in, 1);
      check("rst_wb_valid", mem_to_wb_valid, 0);
      check("rst_bypass_en", mem_to_id_bypass_bus[37], 0);
      check("rst_csr_we", csr_we, 0);
      check("rst_inst_csr", mem_inst_csr, 0);
      @(negedge clk); rst = 1;

      issue(mk(32'h100, 32'h1234, 2'b00, 1, 5'd5, 32'h0, 4'b0000, 32'h0));
      check("alu_valid", mem_to_wb_valid, 1);
      check("alu_wb_data", wb_data, 32'h1234);
      check("alu_bypass", mem_to_id_bypass_bus, {1'b1, 5'd5, 32'h1234});

      issue(mk(32'h8000_0010, 32'h0, 2'b10, 1, 5'd1, 32'h0, 4'b0000, 32'h0));
      check("jal_wb_data", wb_data, 32'h8000_0014);

      issue(mk(32'h104, 32'hF0, 2'b11, 1, 5'd3, 32'h0, 4'b1010, 32'h0F));
      check("csrrs_wb_data", wb_data, 32'h0F);
      check("csrrs_wdata", csr_wdata, 32'hFF);
      check("csrrs_we", csr_we, 1);
      check("csrrs_idx", csr_idx, 12'h300);
      check("csrrs_inst_csr", mem_inst_csr, 1);

      issue(mk(32'h108, 32'h0F, 2'b11, 1, 5'd3, 32'h0, 4'b1011, 32'hFF));
      check("csrrc_wdata", csr_wdata, 32'hF0);

      issue(mk(32'h10C, 32'h55, 2'b11, 1, 5'd3, 32'h0, 4'b1001, 32'hAA));
      check("csrrw_wdata", csr_wdata, 32'h55);

      issue(mk(32'h110, 32'h55, 2'b11, 1, 5'd3, 32'h0, 4'b1000, 32'hAA));
      check("csr_op0_we", csr_we, 0);
      check("csr_op0_wdata", csr_wdata, 32'hAA);

`ifndef DRAM_SYNC_EN
      data_sram_rdata = 32'h1111_1111;
      issue(mk(32'h114, 32'h0, 2'b01, 1, 5'd9, 32'hCAFE_F00D, 4'b0000, 32'h0));
      check("load_wb_data", wb_data, 32'hCAFE_F00D);
`endif

      issue(mk(32'h118, 32'hABCD, 2'b00, 1, 5'd7, 32'h0, 4'b0000, 32'h0));
      wb_allow_in = 0;
      exe_to_mem_bus = mk(32'h11C, 32'h9999, 2'b00, 1, 5'd8, 32'h0, 4'b0000, 32'h0);
      exe_to_mem_valid = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("stall_allow_in", mem_allow_in, 0);
         check("stall_wb_data", wb_data, 32'hABCD);
         check("stall_bypass", mem_to_id_bypass_bus, {1'b1, 5'd7, 32'hABCD});
         check("stall_valid", mem_to_wb_valid, 1);
      end
      wb_allow_in = 1;
      @(posedge clk); #1;
      exe_to_mem_valid = 0;
      check("unstall_wb_data", wb_data, 32'h9999);

      system_flush = 1;
      issue(mk(32'h120, 32'hF0, 2'b11, 1, 5'd3, 32'h0, 4'b1010, 32'h0F));
      system_flush = 0;
      check("flush_valid", mem_valid, 0);
      check("flush_csr_we", csr_we, 0);
      check("flush_bypass_en", mem_to_id_bypass_bus[37], 0);
      check("flush_wb_we", wb_we, 0);

      issue(mk(32'h124, 32'h77, 2'b00, 1, 5'd4, 32'h0, 4'b0000, 32'h0));
      check("pre_arst_valid", mem_valid, 1);
      #1 rst = 0;
      #1;
      check("arst_valid", mem_valid, 0);
      check("arst_wb_data", wb_data, 32'h0);
      @(negedge clk); rst = 1;

`ifdef DRAM_SYNC_EN
      data_sram_rdata = 32'h0;
      issue(mk(32'h128, 32'h0, 2'b01, 1, 5'd9, 32'h0, 4'b0000, 32'h0));
      data_sram_rdata = 32'hDEAD_BEEF;
      wb_allow_in = 0;
      #1 check("sync_first", wb_data, 32'hDEAD_BEEF);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         data_sram_rdata = 32'h0;
         #1 check("sync_hold", wb_data, 32'hDEAD_BEEF);
      end
      wb_allow_in = 1;
      #1 check("sync_leave", wb_data, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      check("sync_gone", mem_valid, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
